// File: rtl/ifu.sv
// Instruction fetch unit: one-outstanding-request fetch FSM feeding a small in-order instruction FIFO.
// Optional misaligned-redirect trapping is built in when IFU_MISALIGN_CHK_EN is defined.
module ifu #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] instr_o,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o,
  output logic [31:0] pc_o,
  output logic        misalign_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetchPc_q, fetchPc_d;
  logic [31:0]   fifoPc_q    [FIFO_DEPTH];
  logic [31:0]   fifoInstr_q [FIFO_DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, countNext;
  logic [31:0]   redirectPc;
  logic          halt, haltNext;
  logic          canFetch, reqActive, granted, push, pop;

`ifdef IFU_MISALIGN_CHK_EN
  logic misalign_q;

  assign redirectPc = redirect_pc_i;
  assign haltNext   = redirect_i ? (redirect_pc_i[1:0] != 2'b00) : misalign_q;
  assign halt       = misalign_q;
  assign misalign_o = misalign_q && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) misalign_q <= 1'b0;
    else       misalign_q <= haltNext;
  end
`else
  assign redirectPc = redirect_pc_i & 32'hFFFF_FFFC;
  assign haltNext   = 1'b0;
  assign halt       = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // IDLE issues its request in the same cycle it sees room, so fetch starts right after reset.
  assign canFetch  = (count_q < CW'(FIFO_DEPTH)) && !halt;
  assign reqActive = !rst_i && ((state_q == REQ) || ((state_q == IDLE) && canFetch));
  assign granted   = reqActive && imem_gnt_i;
  assign push      = (state_q == WAIT) && imem_rvalid_i && !redirect_i;
  assign pop       = id_valid_o && id_ready_i && !redirect_i;
  assign countNext = count_q + CW'(push) - CW'(pop);

  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    if (push)       fetchPc_d = fetchPc_q + 32'd4;
    if (redirect_i) fetchPc_d = redirectPc;
    case (state_q)
      IDLE, REQ: begin
        if (granted)         state_d = redirect_i ? FLUSH : WAIT;
        else if (redirect_i) state_d = haltNext ? IDLE : REQ;
        else if (reqActive)  state_d = REQ;
      end
      WAIT: begin
        if (redirect_i)         state_d = imem_rvalid_i ? (haltNext ? IDLE : REQ) : FLUSH;
        else if (imem_rvalid_i) state_d = (countNext < CW'(FIFO_DEPTH)) ? REQ : IDLE;
      end
      FLUSH: begin
        if (imem_rvalid_i) state_d = haltNext ? IDLE : REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      fetchPc_q <= RESET_PC;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
      if (redirect_i) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) tail_q <= tail_q + PW'(1);
        if (pop)  head_q <= head_q + PW'(1);
        count_q <= countNext;
      end
    end
  end

  // Storage is not reset; the head outputs are masked to zero while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      fifoPc_q[tail_q]    <= fetchPc_q;
      fifoInstr_q[tail_q] <= imem_rdata_i;
    end
  end

  assign id_valid_o  = !rst_i && (count_q != '0);
  assign instr_o     = id_valid_o ? fifoInstr_q[head_q] : 32'h0;
  assign pc_o        = id_valid_o ? fifoPc_q[head_q] : 32'h0;
  assign opcode_o    = instr_o[6:0];
  assign funct3_o    = instr_o[14:12];
  assign imem_req_o  = reqActive;
  assign imem_addr_o = fetchPc_q;
endmodule

// File: tb/tb_ifu.sv
// Testbench for ifu: directed protocol/corner steps followed by a randomized run checked
// against an in-order fetch-stream model and a simple instruction memory.
module tb_ifu;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic        id_ready_i;
  logic [31:0] instr_o;
  logic [6:0]  opcode_o;
  logic [2:0]  funct3_o;
  logic [31:0] pc_o;
  logic        misalign_o;

  int testCount = 0;
  int failCount = 0;

  ifu dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i),
    .instr_o(instr_o), .opcode_o(opcode_o), .funct3_o(funct3_o), .pc_o(pc_o),
    .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;

  // Instruction memory contents as a pure function of the word address.
  function automatic logic [31:0] memData(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // Drives one cycle's inputs shortly after a rising edge and lets outputs settle.
  task automatic applyStimulus(input int rst, input int gnt, input int rvalid,
                               input logic [31:0] rdata, input int redir,
                               input logic [31:0] rpc, input int ready);
    rst_i         = (rst != 0);
    imem_gnt_i    = (gnt != 0);
    imem_rvalid_i = (rvalid != 0);
    imem_rdata_i  = rdata;
    redirect_i    = (redir != 0);
    redirect_pc_i = rpc;
    id_ready_i    = (ready != 0);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic        gnt, rv, redir, rdy, pending, prevHold, prevReqWait;
    logic [31:0] rpc, pendAddr, expPc, prevPc, prevInstr, prevAddr;
    int          lat, delivered;

    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    checkOutput("rstReq", 32'(imem_req_o), 0);
    checkOutput("rstValid", 32'(id_valid_o), 0);
    checkOutput("rstInstr", instr_o, 0);
    checkOutput("rstPc", pc_o, 0);
    checkOutput("rstMisalign", 32'(misalign_o), 0);

    // Reset release: request in the first cycle, granted at once, response next cycle.
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("firstReq", 32'(imem_req_o), 1);
    checkOutput("firstAddr", imem_addr_o, 32'h0);
    tick();
    applyStimulus(0, 0, 1, 32'h0000_0033, 0, 0, 0);
    checkOutput("validNotYet", 32'(id_valid_o), 0);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("firstValid", 32'(id_valid_o), 1);
    checkOutput("firstPc", pc_o, 32'h0);
    checkOutput("firstOpcode", 32'(opcode_o), 32'h33);
    checkOutput("secondAddr", imem_addr_o, 32'h4);
    tick();
    applyStimulus(0, 0, 1, 32'h0000_0413, 0, 0, 0);
    tick();

    // Decode stalled: buffer is full, fetch stops, head stays put.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      checkOutput("fullNoReq", 32'(imem_req_o), 0);
      checkOutput("holdValid", 32'(id_valid_o), 1);
      checkOutput("holdPc", pc_o, 32'h0);
      checkOutput("holdInstr", instr_o, 32'h0000_0033);
      tick();
    end
    applyStimulus(0, 1, 0, 0, 0, 0, 1);
    checkOutput("popPc0", pc_o, 32'h0);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 1);
    checkOutput("popPc4", pc_o, 32'h4);
    checkOutput("popOpcode4", 32'(opcode_o), 32'h13);
    checkOutput("popFunct3_4", 32'(funct3_o), 0);
    checkOutput("refetchReq", 32'(imem_req_o), 1);
    checkOutput("refetchAddr", imem_addr_o, 32'h8);
    tick();
    applyStimulus(0, 0, 1, 32'h0000_2803, 0, 0, 1);
    checkOutput("onlyTwoBuffered", 32'(id_valid_o), 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("pc8Valid", 32'(id_valid_o), 1);
    checkOutput("pc8", pc_o, 32'h8);
    checkOutput("funct3_8", 32'(funct3_o), 2);
    checkOutput("opcode8", 32'(opcode_o), 32'h03);
    tick();

    // Redirect while waiting: stale response must be dropped.
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("addrC", imem_addr_o, 32'hC);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 32'h100, 0);
    tick();
    applyStimulus(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    checkOutput("flushNoReq", 32'(imem_req_o), 0);
    checkOutput("flushValid", 32'(id_valid_o), 0);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("staleValid", 32'(id_valid_o), 0);
    checkOutput("staleInstr", instr_o, 32'h0);
    checkOutput("redirReq", 32'(imem_req_o), 1);
    checkOutput("redirAddr", imem_addr_o, 32'h100);
    tick();

    // Redirect coinciding with the response: dropped, request to new PC immediately.
    applyStimulus(0, 0, 1, 32'hDEAD_BEEF, 1, 32'h200, 0);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("coincValid", 32'(id_valid_o), 0);
    checkOutput("coincReq", 32'(imem_req_o), 1);
    checkOutput("coincAddr", imem_addr_o, 32'h200);
    tick();
    applyStimulus(0, 0, 1, 32'h0000_0093, 0, 0, 0);
    tick();

    // Address wrap at the top of memory.
    applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0);
    checkOutput("pc200", pc_o, 32'h200);
    checkOutput("instr200", instr_o, 32'h0000_0093);
    tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("topFlushed", 32'(id_valid_o), 0);
    checkOutput("topAddr", imem_addr_o, 32'hFFFF_FFFC);
    tick();
    applyStimulus(0, 0, 1, 32'h0000_0013, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("topPc", pc_o, 32'hFFFF_FFFC);
    checkOutput("wrapReq", 32'(imem_req_o), 1);
    checkOutput("wrapAddr", imem_addr_o, 32'h0);
    tick();

    // Misaligned redirect target.
    applyStimulus(0, 0, 0, 0, 1, 32'h102, 0);
    tick();
`ifdef IFU_MISALIGN_CHK_EN
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      checkOutput("misalignSet", 32'(misalign_o), 1);
      checkOutput("misalignNoReq", 32'(imem_req_o), 0);
      checkOutput("misalignValid", 32'(id_valid_o), 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 1, 32'h200, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("misalignClear", 32'(misalign_o), 0);
    checkOutput("realignReq", 32'(imem_req_o), 1);
    checkOutput("realignAddr", imem_addr_o, 32'h200);
`else
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("misalignTied", 32'(misalign_o), 0);
    checkOutput("forcedReq", 32'(imem_req_o), 1);
    checkOutput("forcedAddr", imem_addr_o, 32'h100);
    checkOutput("forcedFlush", 32'(id_valid_o), 0);
`endif

    // Reset with a request outstanding; responses around reset must be ignored.
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    checkOutput("midRstReq", 32'(imem_req_o), 0);
    checkOutput("midRstValid", 32'(id_valid_o), 0);
    tick();
    applyStimulus(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    checkOutput("postRstReq", 32'(imem_req_o), 1);
    checkOutput("postRstAddr", imem_addr_o, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("postRstIgnored", 32'(id_valid_o), 0);
    tick();

    // Randomized traffic: delivered stream must be sequential from the last redirect.
    pending = 1'b0; lat = 0; pendAddr = 32'h0; expPc = 32'h0; delivered = 0;
    prevHold = 1'b0; prevReqWait = 1'b0; prevPc = 32'h0; prevInstr = 32'h0; prevAddr = 32'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      gnt   = ($urandom_range(0, 1) == 1);
      rv    = pending && (lat == 0);
      redir = ($urandom_range(0, 39) == 0);
      rpc   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_3FFC);
      rdy   = ($urandom_range(0, 3) != 0);
      applyStimulus(0, int'(gnt), int'(rv), memData(pendAddr), int'(redir), rpc, int'(rdy));

      checkOutput("oneOutstanding", 32'(pending && imem_req_o), 0);
      if (prevHold) begin
        checkOutput("rndHoldValid", 32'(id_valid_o), 1);
        checkOutput("rndHoldPc", pc_o, prevPc);
        checkOutput("rndHoldInstr", instr_o, prevInstr);
      end
      if (prevReqWait) begin
        checkOutput("rndReqHeld", 32'(imem_req_o), 1);
        checkOutput("rndAddrStable", imem_addr_o, prevAddr);
      end
      if (id_valid_o && rdy && !redir) begin
        checkOutput("rndPc", pc_o, expPc);
        checkOutput("rndInstr", instr_o, memData(expPc));
        expPc = expPc + 32'd4;
        delivered++;
      end
      if (redir) expPc = rpc;

      prevHold    = id_valid_o && !rdy && !redir;
      prevPc      = pc_o;
      prevInstr   = instr_o;
      prevReqWait = imem_req_o && !gnt && !redir;
      prevAddr    = imem_addr_o;
      if (rv) pending = 1'b0;
      else if (pending && lat != 0) lat--;
      if (imem_req_o && gnt) begin
        pending  = 1'b1;
        pendAddr = imem_addr_o;
        lat      = int'($urandom_range(0, 2));
      end
      tick();
    end
    checkOutput("liveness", 32'(delivered > 200), 1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
